// File: rtl/draw_symbol_gen.sv
// Symbol rasteriser: raster-scans a SIZE x SIZE cell from a latched anchor and
// emits one registered pixel per cycle, strobing plot on pixels inside the shape.
module draw_symbol_gen #(
    parameter int SIZE     = 16,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                stall,
    output logic [X_W-1:0]      xout,
    output logic [Y_W-1:0]      yout,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    // Handshake: start is a level sampled only in IDLE; while busy the scan
    // advances one pixel on every edge where stall is low, and done marks the
    // edge that registers the final pixel.

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST     = CW'(SIZE - 1);
    localparam logic [CW:0]   LAST_SUM = (CW + 1)'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]       i, j;
    logic [X_W-1:0]      x_l;
    logic [Y_W-1:0]      y_l;
    logic [1:0]          mode_l;
    logic [COLOUR_W-1:0] colour_l;

    logic       accept;
    logic       advance;
    logic       last_pix;
    logic       in_shape;
    logic [CW:0] diag_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        advance    = 1'b0;
        last_pix   = (i == LAST) && (j == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (!stall) begin
                    advance = 1'b1;
                    if (last_pix) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        in_shape = 1'b0;
        diag_sum = {1'b0, i} + {1'b0, j};
        case (mode_l)
            2'd0:    in_shape = (i == j) || (diag_sum == LAST_SUM);
            2'd1:    in_shape = (i == '0) || (j == '0) || (i == LAST) || (j == LAST);
            default: in_shape = 1'b1;
        endcase
    end

    assign busy      = (state == DRAW);
    assign state_dbg = state;

    // Coordinates wrap modulo 2^W on purpose; there is no clipping at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i          <= '0;
            j          <= '0;
            x_l        <= '0;
            y_l        <= '0;
            mode_l     <= '0;
            colour_l   <= '0;
            xout       <= '0;
            yout       <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            done       <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            if (accept) begin
                x_l      <= x;
                y_l      <= y;
                mode_l   <= mode;
                colour_l <= colour;
                i        <= '0;
                j        <= '0;
            end else if (advance) begin
                xout       <= x_l + X_W'(i);
                yout       <= y_l + Y_W'(j);
                colour_out <= (mode_l == 2'd3) ? '0 : colour_l;
                plot       <= in_shape;
                done       <= last_pix;
                if (i == LAST) begin
                    i <= '0;
                    j <= (j == LAST) ? '0 : j + 1'b1;
                end else begin
                    i <= i + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_draw_symbol_gen.sv
// Bench for draw_symbol_gen: a shape model fills an expected-pixel queue per
// symbol, and a negedge monitor pops and compares every plotted pixel.
module tb_draw_symbol_gen;

    localparam int SIZE     = 16;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int PW       = X_W + Y_W + COLOUR_W;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [1:0]          mode;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                stall;
    logic [X_W-1:0]      xout;
    logic [Y_W-1:0]      yout;
    logic [COLOUR_W-1:0] colour_out;
    logic                plot;
    logic                busy;
    logic                done;
    logic [1:0]          state_dbg;

    int errors = 0;
    int checks = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_pix;

    draw_symbol_gen #(
        .SIZE(SIZE), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .x(x), .y(y), .colour(colour), .stall(stall),
        .xout(xout), .yout(yout), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (plot) begin
                plot_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_plot", {xout, yout, colour_out}, 32'hffff_ffff);
                end else begin
                    exp_pix = exp_q.pop_front();
                    check("pixel", {xout, yout, colour_out}, exp_pix);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_with_plot", plot, 1);
            end
        end
    end

    task automatic push_expected(input int m, input int xa, input int ya, input int c, output int n);
        bit hit;
        logic [X_W-1:0] xe;
        logic [Y_W-1:0] ye;
        logic [COLOUR_W-1:0] ce;
        n = 0;
        for (int jj = 0; jj < SIZE; jj++) begin
            for (int ii = 0; ii < SIZE; ii++) begin
                case (m)
                    0:       hit = (ii == jj) || (ii + jj == SIZE - 1);
                    1:       hit = (ii == 0) || (jj == 0) || (ii == SIZE - 1) || (jj == SIZE - 1);
                    default: hit = 1'b1;
                endcase
                if (hit) begin
                    xe = X_W'((xa + ii) % (1 << X_W));
                    ye = Y_W'((ya + jj) % (1 << Y_W));
                    ce = (m == 3) ? '0 : COLOUR_W'(c);
                    exp_q.push_back({xe, ye, ce});
                    n++;
                end
            end
        end
    endtask

    task automatic scramble_inputs();
        mode   = 2'($urandom_range(0, 3));
        x      = X_W'($urandom_range(0, 255));
        y      = Y_W'($urandom_range(0, 127));
        colour = COLOUR_W'($urandom_range(0, 7));
    endtask

    // k counts edges after the acceptance edge; returns the edge where done shows
    task automatic wait_done(input int first_k, input int stall_at, input int stall_len,
                             input bit poke_mid, output int k_done);
        logic [X_W-1:0] x_hold;
        x_hold = '0;
        k_done = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            if (k == first_k) check("first_plot", plot, 1);
            if (stall_len > 0) begin
                if (k == stall_at) begin
                    stall  = 1'b1;
                    x_hold = xout;
                end else if (k > stall_at && k <= stall_at + stall_len) begin
                    check("stall_plot_low", plot, 0);
                    check("stall_x_hold", xout, x_hold);
                    if (k == stall_at + stall_len) stall = 1'b0;
                end
            end
            if (poke_mid) begin
                if (k == 50) begin
                    scramble_inputs();
                    start = 1'b1;
                end else if (k == 51) begin
                    start = 1'b0;
                end
            end
            if (done) begin
                k_done = k;
                break;
            end
        end
        if (k_done < 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_symbol(input int m, input int xa, input int ya, input int c,
                              input int stall_at, input int stall_len,
                              input bit poke_mid, input bit poke_done);
        int n, pc0, dc0, kd;
        push_expected(m, xa, ya, c, n);
        pc0 = plot_cnt;
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        start  = 1'b1;
        mode   = 2'(m);
        x      = X_W'(xa);
        y      = Y_W'(ya);
        colour = COLOUR_W'(c);
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        check("busy_after_start", busy, 1);
        check("no_plot_at_accept", plot, 0);
        wait_done(1, stall_at, stall_len, poke_mid, kd);
        check("done_cycle", kd, SIZE * SIZE + stall_len);
        if (poke_done) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(negedge clk);
        #1;
        check("plot_count", plot_cnt - pc0, n);
        check("done_count", done_cnt - dc0, 1);
        check("queue_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_plot", plot, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        int n1, n2, pc0, dc0, kd;
        reset_n = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        mode    = '0;
        x       = '0;
        y       = '0;
        colour  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {xout, yout, colour_out, plot, busy, done}, 0);
        check("reset_state", state_dbg, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_symbol(0, 10, 20, 5, 0, 0, 0, 0);
        run_symbol(1, 0, 0, 3, 0, 0, 1, 1);
        run_symbol(3, 100, 50, 7, 0, 0, 0, 0);
        run_symbol(2, 250, 120, $urandom_range(0, 7), 0, 0, 0, 0);
        run_symbol(2, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7), 40, 3, 0, 0);
        for (int r = 0; r < 2; r++) begin
            run_symbol($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 127),
                       $urandom_range(0, 7), $urandom_range(5, 200), $urandom_range(1, 4), 0, 0);
        end

        // start held high: second draw is accepted on the first IDLE edge after DONE
        push_expected(1, 30, 40, 2, n1);
        push_expected(1, 30, 40, 2, n2);
        pc0 = plot_cnt;
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        start  = 1'b1;
        mode   = 2'd1;
        x      = X_W'(30);
        y      = Y_W'(40);
        colour = COLOUR_W'(2);
        @(posedge clk);
        #1;
        wait_done(1, 0, 0, 0, kd);
        check("b2b_first_done", kd, SIZE * SIZE);
        wait_done(3, 0, 0, 0, kd);
        check("b2b_second_done", kd, SIZE * SIZE + 2);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("b2b_plot_count", plot_cnt - pc0, n1 + n2);
        check("b2b_done_count", done_cnt - dc0, 2);
        check("b2b_queue_drained", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_idle", busy, 0);

        // reset during a draw aborts immediately
        push_expected(2, 60, 30, 4, n1);
        @(posedge clk);
        #1;
        start  = 1'b1;
        mode   = 2'd2;
        x      = X_W'(60);
        y      = Y_W'(30);
        colour = COLOUR_W'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {xout, yout, colour_out, plot, busy, done}, 0);
        check("abort_state", state_dbg, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pc0 = plot_cnt;
        dc0 = done_cnt;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("post_reset_quiet", {plot, done, busy}, 0);
        end
        check("post_reset_plots", plot_cnt - pc0, 0);
        check("post_reset_done", done_cnt - dc0, 0);

        run_symbol(0, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7), 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
